// File: rtl/debounce_pkg.sv
// Shared definitions for the debouncer family.
//
// Contents:
//   db_state_t      - per-channel debounce FSM state encoding
//   DEF_*           - default parameter values shared by debouncer variants
package debounce_pkg;

  // ZERO/ONE are the settled levels.
  // HOLD1/HOLD0 are the blind windows that follow an accepted edge.
  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    HOLD1 = 2'd1,
    ONE   = 2'd2,
    HOLD0 = 2'd3
  } db_state_t;

  localparam int   DEF_N_CH        = 4;
  localparam int   DEF_TICK_CYCLES = 1_000_000;  // 10 ms at 100 MHz
  localparam int   DEF_HOLD_TICKS  = 3;
  localparam int   DEF_SYNC_STAGES = 2;
  localparam logic DEF_IDLE_LEVEL  = 1'b0;

endpackage

// File: rtl/tick_gen.sv
// Shared hold-tick prescaler.
//
// A free-running counter counts 0..TICK_CYCLES-1 and then wraps.
// tick is high for the one cycle in which the count sits at TICK_CYCLES-1.
// After reset is released, the first tick is therefore sampled
// TICK_CYCLES clocks later.
//
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset (clears the count)
//   tick  - one-cycle pulse every TICK_CYCLES clocks
module tick_gen
  import debounce_pkg::*;
#(
  parameter int TICK_CYCLES = DEF_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CW   = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/multi_early_debouncer.sv
// Multi-channel early-response debouncer.
//
// Each channel synchronises its raw switch input. The first edge of the
// synchronised level is accepted immediately. The channel then goes blind
// for HOLD_TICKS ticks of the shared prescaler. The tick that coincides
// with the accepting edge is not counted, so the blind window lasts
// between (HOLD_TICKS-1)*TICK_CYCLES and HOLD_TICKS*TICK_CYCLES clocks.
//
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset
//   sw    - raw asynchronous switch inputs, one per channel
//   db    - debounced levels (IDLE_LEVEL after reset)
//   rise  - one-cycle pulse on the edge where db[i] goes 0->1
//   fall  - one-cycle pulse on the edge where db[i] goes 1->0
//   busy  - high while channel i is in HOLD1 or HOLD0
//
// Per-channel FSM states are collected in the st array so that
// checkers can bind to them.
module multi_early_debouncer
  import debounce_pkg::*;
#(
  parameter int   N_CH        = DEF_N_CH,
  parameter int   TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int   HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic IDLE_LEVEL  = DEF_IDLE_LEVEL
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] db,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic [N_CH-1:0] busy
);

  localparam int             HCW     = $clog2(HOLD_TICKS + 1);
  localparam logic [HCW-1:0] LAST_HC = HCW'(HOLD_TICKS - 1);
  localparam db_state_t      IDLE_ST = IDLE_LEVEL ? ONE : ZERO;

  logic      tick;
  db_state_t st [N_CH];

  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    db_state_t              st_q;
    logic [HCW-1:0]         hc;
    logic                   db_q;
    logic                   busy_q;
    logic                   rise_q;
    logic                   fall_q;

    // The synchroniser resets to the idle level. A switch that is already
    // at the idle level after reset therefore produces no spurious edge.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= {SYNC_STAGES{IDLE_LEVEL}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // db, busy, rise and fall are registered next to the state. They
    // change on the same edge as the state transition that defines them.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st_q   <= IDLE_ST;
        hc     <= '0;
        db_q   <= IDLE_LEVEL;
        busy_q <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (st_q)
          ZERO: begin
            // A tick in this cycle is deliberately not counted toward the hold.
            if (s) begin
              st_q   <= HOLD1;
              hc     <= '0;
              db_q   <= 1'b1;
              busy_q <= 1'b1;
              rise_q <= 1'b1;
            end
          end
          HOLD1: begin
            if (tick) begin
              if (hc == LAST_HC) begin
                st_q   <= ONE;
                busy_q <= 1'b0;
              end else begin
                hc <= hc + 1'b1;
              end
            end
          end
          ONE: begin
            if (!s) begin
              st_q   <= HOLD0;
              hc     <= '0;
              db_q   <= 1'b0;
              busy_q <= 1'b1;
              fall_q <= 1'b1;
            end
          end
          HOLD0: begin
            if (tick) begin
              if (hc == LAST_HC) begin
                st_q   <= ZERO;
                busy_q <= 1'b0;
              end else begin
                hc <= hc + 1'b1;
              end
            end
          end
          default: begin
            st_q   <= IDLE_ST;
            hc     <= '0;
            db_q   <= IDLE_LEVEL;
            busy_q <= 1'b0;
          end
        endcase
      end
    end

    assign st[i]   = st_q;
    assign db[i]   = db_q;
    assign busy[i] = busy_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

endmodule

// File: tb/tb_multi_early_debouncer.sv
// Directed bench for multi_early_debouncer.
// The bench uses N_CH=2, TICK_CYCLES=4, HOLD_TICKS=3 and SYNC_STAGES=2.
// dut0 runs with IDLE_LEVEL=0 and dut1 with IDLE_LEVEL=1.
//
// Timing reference: cyc counts rising edges since the last reset release.
// Inputs are driven and outputs sampled on the falling edge after that
// rising edge. Prescaler ticks are therefore sampled at cyc = 4, 8, 12, ...
module tb_multi_early_debouncer;

  logic       clk;
  logic       reset;
  logic [1:0] sw0, db0, rise0, fall0, busy0;
  logic [1:0] sw1, db1, rise1, fall1, busy1;

  int total;
  int bad;
  int cyc;

  logic [3:0] exp_q[$];

  multi_early_debouncer #(
    .N_CH(2), .TICK_CYCLES(4), .HOLD_TICKS(3), .SYNC_STAGES(2), .IDLE_LEVEL(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .sw(sw0), .db(db0), .rise(rise0), .fall(fall0), .busy(busy0)
  );

  multi_early_debouncer #(
    .N_CH(2), .TICK_CYCLES(4), .HOLD_TICKS(3), .SYNC_STAGES(2), .IDLE_LEVEL(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .sw(sw1), .db(db1), .rise(rise1), .fall(fall1), .busy(busy1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic do_reset();
    sw0   = 2'b00;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    cyc   = 0;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  int n_rise, n_fall, n_drop;

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    sw0   = 2'b00;
    sw1   = 2'b00;
    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset values for both idle levels.
    chk("rst_db0",   db0,   2'b00);
    chk("rst_rise0", rise0, 2'b00);
    chk("rst_fall0", fall0, 2'b00);
    chk("rst_busy0", busy0, 2'b00);
    chk("rst_db1",   db1,   2'b11);
    chk("rst_pulse1", {rise1, fall1, busy1}, 6'b0);
    reset = 1'b1;
    cyc   = 0;

    // IDLE_LEVEL=1 with sw held low: fall appears SYNC_STAGES+1 edges after release.
    step_to(2);
    chk("idle1_db_c2",   db1,   2'b11);
    chk("idle1_fall_c2", fall1, 2'b00);
    step_to(3);
    chk("idle1_db_c3",   db1,   2'b00);
    chk("idle1_fall_c3", fall1, 2'b11);
    chk("idle1_busy_c3", busy1, 2'b11);
    step_to(4);
    chk("idle1_fall_c4", fall1, 2'b00);

    // Clean press: sw[0] rises after edge 10, so db and rise appear at edge 13.
    // The hold ticks are sampled at edges 16, 20 and 24, so busy is high
    // for edges 13..23. Each trace entry is {fall, rise, busy, db} for channel 0.
    step_to(10);
    sw0 = 2'b01;
    for (int e = 11; e <= 26; e++) begin
      exp_q.push_back({1'b0, (e == 13) ? 1'b1 : 1'b0,
                       (e >= 13 && e <= 23) ? 1'b1 : 1'b0,
                       (e >= 13) ? 1'b1 : 1'b0});
    end
    for (int e = 11; e <= 26; e++) begin
      step();
      chk("press_trace", {fall0[0], rise0[0], busy0[0], db0[0]}, exp_q.pop_front());
      if (e == 13) chk("press_ch1_quiet", {db0[1], busy0[1], rise0[1], fall0[1]}, 4'b0);
    end

    // Bounce: sw[0] toggles every cycle for 8 cycles after the first rise.
    do_reset();
    step_to(10);
    sw0 = 2'b01;
    n_rise = 0;
    n_fall = 0;
    n_drop = 0;
    for (int e = 11; e <= 40; e++) begin
      step();
      if (rise0[0]) n_rise++;
      if (fall0[0]) n_fall++;
      if (e >= 13 && db0[0] !== 1'b1) n_drop++;
      if (e <= 18) sw0[0] = ~sw0[0];
    end
    chk("bounce_rise_cnt", n_rise, 1);
    chk("bounce_fall_cnt", n_fall, 0);
    chk("bounce_db_drop",  n_drop, 0);
    chk("bounce_busy_end", busy0, 2'b00);

    // Release during hold: the release after edge 15 is ignored until the
    // hold expires at edge 24. fall follows at edge 25, and HOLD0 expires at edge 36.
    do_reset();
    step_to(10);
    sw0 = 2'b01;
    step_to(15);
    sw0 = 2'b00;
    step_to(23);
    chk("rel_held_db",   db0[0],   1'b1);
    chk("rel_held_busy", busy0[0], 1'b1);
    step_to(24);
    chk("rel_one", {fall0[0], busy0[0], db0[0]}, 3'b001);
    step_to(25);
    chk("rel_fall", {fall0[0], busy0[0], db0[0]}, 3'b110);
    step_to(26);
    chk("rel_fall_width", fall0[0], 1'b0);
    step_to(35);
    chk("rel_hold0_busy", busy0[0], 1'b1);
    step_to(36);
    chk("rel_zero", {busy0[0], db0[0]}, 2'b00);

    // Simultaneous edges on both channels.
    do_reset();
    step_to(10);
    sw0 = 2'b11;
    step_to(12);
    chk("simul_rise_c12", rise0, 2'b00);
    step_to(13);
    chk("simul_rise_c13", rise0, 2'b11);
    chk("simul_db_c13",   db0,   2'b11);
    step_to(14);
    chk("simul_rise_c14", rise0, 2'b00);
    step_to(23);
    chk("simul_busy_c23", busy0, 2'b11);
    step_to(24);
    chk("simul_busy_c24", busy0, 2'b00);
    chk("simul_db_c24",   db0,   2'b11);

    // Async reset mid-HOLD1. The prescaler restarts, so ticks are sampled
    // at edges 4, 8, ... after release. A press after edge 5 is accepted at
    // edge 8; the tick at that edge is not counted, so expiry is at edge 20.
    do_reset();
    step_to(10);
    sw0 = 2'b01;
    step_to(16);
    chk("areset_pre", {busy0[0], db0[0]}, 2'b11);
    sw0 = 2'b00;
    #2 reset = 1'b0;
    #1;
    chk("areset_db0",    db0,   2'b00);
    chk("areset_busy0",  busy0, 2'b00);
    chk("areset_pulse0", {rise0, fall0}, 4'b0);
    chk("areset_db1",    db1,   2'b11);
    reset = 1'b1;
    cyc   = 0;
    step_to(5);
    sw0 = 2'b01;
    step_to(7);
    chk("areset_lat_c7", db0[0], 1'b0);
    step_to(8);
    chk("areset_lat_c8", {rise0[0], busy0[0], db0[0]}, 3'b111);
    step_to(19);
    chk("areset_busy_c19", busy0[0], 1'b1);
    step_to(20);
    chk("areset_busy_c20", {busy0[0], db0[0]}, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
